fm_demodulator: RTL

Receive-side counterpart of the FM modulator. Accepts complex baseband I/Q samples at the RF sample rate `FS_IN`, where the FM carrier sits at `FC_IN`. Recovers the instantaneous phase with an iterative vectoring CORDIC, differentiates it, and removes the carrier phase step. It then decimates to the audio rate `FS_OUT` with an accumulate-and-dump filter. The block sits between the RF sample source and the audio sink.

---
 rtl/fm_demodulator.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fm_demodulator.sv
// FM demodulator: vectoring CORDIC phase detector, phase differentiator with
// carrier removal, and accumulate-and-dump decimator to the audio rate.
// Optional feature: define FM_DEMOD_DEEMPH_EN to add a first-order de-emphasis
// IIR on the decimated output (adds one cycle of output latency).
`timescale 1ns/1ps
module fm_demodulator #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned FS_IN        = 4800000,
    parameter int unsigned FS_OUT       = 48000,
    parameter int unsigned FC_IN        = 1000000,
    parameter int unsigned ITER         = 14,
    parameter int unsigned DEEMPH_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [WIDTH-1:0] data_in_q,
    input  logic             stb_in,
    output logic [WIDTH-1:0] data_out,
    output logic             stb_out,
    output logic             overrun
);
    localparam int unsigned R    = FS_IN / FS_OUT;
    localparam int unsigned SH   = $clog2(R);
    localparam int unsigned ACCW = WIDTH + SH;
    localparam int unsigned XW   = WIDTH + 2;
    localparam int unsigned IW   = (ITER > 1) ? $clog2(ITER) : 1;
    // Multiply before dividing so the carrier step keeps its fractional precision.
    localparam logic [63:0] WC64 = (64'(FC_IN) * (64'd1 << WIDTH)) / 64'(FS_IN);
    localparam logic [WIDTH-1:0] WC = WC64[WIDTH-1:0];

    typedef enum logic [1:0] {StIdle, StPre, StRot, StPost} state_e;

    // atan(2^-i) with a full circle of 2^32, truncated to the top WIDTH bits.
    function automatic logic [WIDTH-1:0] atan_lut(input logic [4:0] idx);
        logic [31:0] t;
        case (idx)
            5'd0:    t = 32'h2000_0000;
            5'd1:    t = 32'h12E4_051E;
            5'd2:    t = 32'h09FB_385B;
            5'd3:    t = 32'h0511_11D4;
            5'd4:    t = 32'h028B_0D43;
            5'd5:    t = 32'h0145_D7E1;
            5'd6:    t = 32'h00A2_F61E;
            5'd7:    t = 32'h0051_7C55;
            5'd8:    t = 32'h0028_BE53;
            5'd9:    t = 32'h0014_5F2F;
            5'd10:   t = 32'h000A_2F98;
            5'd11:   t = 32'h0005_17CC;
            5'd12:   t = 32'h0002_8BE6;
            5'd13:   t = 32'h0001_45F3;
            5'd14:   t = 32'h0000_A2FA;
            5'd15:   t = 32'h0000_517D;
            default: t = 32'h0000_0000;
        endcase
        return t[31 -: WIDTH];
    endfunction

    state_e                  state_q;
    logic signed [XW-1:0]    x_q, y_q;
    logic [WIDTH-1:0]        z_q;
    logic [IW-1:0]           i_q;
    logic [WIDTH-1:0]        prev_q;
    logic                    prev_valid_q;
    logic [ACCW-1:0]         acc_q;
    logic [7:0]              cnt_q;
    logic [WIDTH-1:0]        dec_q;
    logic                    dec_stb_q;
    logic                    ovr_q;

    logic signed [XW-1:0]    x_d, y_d, xs, ys;
    logic [WIDTH-1:0]        z_d, atan_i, dphi;
    logic [ACCW-1:0]         acc_sum;
    logic [7:0]              cnt_inc;

    // One CORDIC micro-rotation plus the differentiator/accumulator arithmetic.
    always_comb begin
        xs     = x_q >>> i_q;
        ys     = y_q >>> i_q;
        atan_i = atan_lut(5'(i_q));
        if (!y_q[XW-1]) begin
            x_d = x_q + ys;
            y_d = y_q - xs;
            z_d = z_q + atan_i;
        end else begin
            x_d = x_q - ys;
            y_d = y_q + xs;
            z_d = z_q - atan_i;
        end
        // Modulo-2^WIDTH arithmetic makes +/-pi crossings come out as small steps.
        dphi    = z_q - prev_q - WC;
        acc_sum = acc_q + {{SH{dphi[WIDTH-1]}}, dphi};
        cnt_inc = cnt_q + 8'd1;
    end

    // Sample capture, quadrant fold, CORDIC iterations and decimation control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            i_q          <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            dec_q        <= '0;
            dec_stb_q    <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            dec_stb_q <= 1'b0;
            // A strobe while busy is dropped without touching the datapath.
            ovr_q     <= stb_in && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (stb_in) begin
                        x_q     <= {{2{data_in_i[WIDTH-1]}}, data_in_i};
                        y_q     <= {{2{data_in_q[WIDTH-1]}}, data_in_q};
                        state_q <= StPre;
                    end
                end
                StPre: begin
                    // Rotate left-half-plane vectors by pi so CORDIC converges.
                    if (x_q[XW-1]) begin
                        x_q <= -x_q;
                        y_q <= -y_q;
                        z_q <= {1'b1, {(WIDTH-1){1'b0}}};
                    end else begin
                        z_q <= '0;
                    end
                    i_q     <= '0;
                    state_q <= StRot;
                end
                StRot: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    i_q <= i_q + IW'(1);
                    if (i_q == IW'(ITER - 1)) begin
                        state_q <= StPost;
                    end
                end
                StPost: begin
                    prev_q <= z_q;
                    if (!prev_valid_q) begin
                        prev_valid_q <= 1'b1;
                    end else if (cnt_inc == 8'(R)) begin
                        dec_q     <= acc_sum[ACCW-1 -: WIDTH];
                        dec_stb_q <= 1'b1;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                    end else begin
                        acc_q <= acc_sum;
                        cnt_q <= cnt_inc;
                    end
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign overrun = ovr_q;

`ifdef FM_DEMOD_DEEMPH_EN
    localparam int unsigned DW = WIDTH + DEEMPH_SHIFT;

    logic signed [DW-1:0] de_q;
    logic                 de_stb_q;
    logic signed [DW:0]   de_diff, de_step;

    // De-emphasis update term: (x - y) >>> shift with x aligned to the state.
    always_comb begin
        de_diff = {dec_q[WIDTH-1], dec_q, {DEEMPH_SHIFT{1'b0}}} - {de_q[DW-1], de_q};
        de_step = de_diff >>> DEEMPH_SHIFT;
    end

    // One-pole IIR on each decimated sample; strobe trails by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q     <= '0;
            de_stb_q <= 1'b0;
        end else begin
            de_stb_q <= dec_stb_q;
            if (dec_stb_q) begin
                de_q <= de_q + de_step[DW-1:0];
            end
        end
    end

    assign data_out = de_q[DW-1 -: WIDTH];
    assign stb_out  = de_stb_q;
`else
    assign data_out = dec_q;
    assign stb_out  = dec_stb_q;
`endif

endmodule
